multicycle_controller: RTL and testbench

- Control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, instruction register, PC and register-file write port over several cycles per instruction.
- Drives imm_src to the immediate extender and decodes ALU control through the alu_decoder sub-module.
- Supported instructions: lw, sw, R-type ALU ops, I-type ALU ops, beq/bne, jal; anything else is flagged illegal and skipped.

---
 rtl/definitions_pkg.sv | 69 ++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcodes, datapath select encodings and ALU operation codes.
package definitions_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } ctrl_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // funct3 codes 001 (shift left), 101 (shift right) and 011 (sltu) have
    // no ALU operation code, so R/I instructions using them are illegal.
    function automatic logic alu_funct3_legal(input logic [2:0] funct3);
        return !(funct3 == 3'b001 || funct3 == 3'b101 || funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's internal alu_op and the instruction funct fields
// onto the ALU operation code.
module alu_decoder
    import definitions_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op_b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALU_OP_SUB: o_alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (i_funct3)
                    // op bit 5 separates R-type from I-type: addi never subtracts.
                    3'b000:  o_alu_control = (i_op_b5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM. Define MULTICYCLE_MEM_WAIT_EN to add the
// mem_ready_i port and hold FETCH/MEMREAD/MEMWRITE until memory is ready.
module multicycle_controller
    import definitions_pkg::*;
#(
    parameter ctrl_state_e RESET_STATE = FETCH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        zero_i,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  logic        mem_ready_i,
`endif
    output logic        pc_write_o,
    output logic        adr_src_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  imm_src_o,
    output logic [2:0]  alu_control_o,
    output logic        illegal_instr_o,
    output logic        instr_retire_o,
    output ctrl_state_e state_o
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;

    logic       w_mem_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_illegal;
    logic       w_retire;
    logic [2:0] w_alu_control;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign w_mem_ready = mem_ready_i;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRC_A_PC;
        w_alu_src_b  = SRC_B_RS2;
        w_alu_op     = ALU_OP_ADD;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;

        case (r_state)
            FETCH: begin
                w_alu_src_a  = SRC_A_PC;
                w_alu_src_b  = SRC_B_FOUR;
                w_result_src = RES_ALU;
                if (w_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_update  = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch/jal target into ALUOut.
                w_alu_src_a = SRC_A_OLDPC;
                w_alu_src_b = SRC_B_IMM;
                case (op_i)
                    OP_LOAD, OP_STORE: w_next_state = MEMADR;
                    OP_R:      w_next_state = alu_funct3_legal(funct3_i) ? EXECUTER : FETCH;
                    OP_I:      w_next_state = alu_funct3_legal(funct3_i) ? EXECUTEI : FETCH;
                    OP_BRANCH: w_next_state = (funct3_i[2:1] == 2'b00) ? BRANCH : FETCH;
                    OP_JAL:    w_next_state = JAL;
                    default:   w_next_state = FETCH;
                endcase
                if (w_next_state == FETCH) begin
                    w_illegal = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            MEMADR: begin
                w_alu_src_a  = SRC_A_RS1;
                w_alu_src_b  = SRC_B_IMM;
                w_next_state = (op_i == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
                if (w_mem_ready) begin
                    w_next_state = MEMWB;
                end
            end
            MEMWB: begin
                w_result_src = RES_RDATA;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            MEMWRITE: begin
                w_adr_src = 1'b1;
                if (w_mem_ready) begin
                    w_mem_write  = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = FETCH;
                end
            end
            EXECUTER: begin
                w_alu_src_a  = SRC_A_RS1;
                w_alu_src_b  = SRC_B_RS2;
                w_alu_op     = ALU_OP_FUNCT;
                w_next_state = ALUWB;
            end
            EXECUTEI: begin
                w_alu_src_a  = SRC_A_RS1;
                w_alu_src_b  = SRC_B_IMM;
                w_alu_op     = ALU_OP_FUNCT;
                w_next_state = ALUWB;
            end
            ALUWB: begin
                w_result_src = RES_ALUOUT;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            BRANCH: begin
                w_alu_src_a  = SRC_A_RS1;
                w_alu_src_b  = SRC_B_RS2;
                w_result_src = RES_ALUOUT;
                w_alu_op     = ALU_OP_SUB;
                w_branch     = 1'b1;
                w_retire     = 1'b1;
                w_next_state = FETCH;
            end
            JAL: begin
                // PC takes the target from ALUOut while the ALU forms oldPC+4 for rd.
                w_alu_src_a  = SRC_A_OLDPC;
                w_alu_src_b  = SRC_B_FOUR;
                w_result_src = RES_ALUOUT;
                w_pc_update  = 1'b1;
                w_next_state = ALUWB;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase

        if (rst_i) begin
            w_pc_update  = 1'b0;
            w_branch     = 1'b0;
            w_adr_src    = 1'b0;
            w_mem_write  = 1'b0;
            w_ir_write   = 1'b0;
            w_reg_write  = 1'b0;
            w_result_src = RES_ALU;
            w_alu_src_a  = SRC_A_PC;
            w_alu_src_b  = SRC_B_FOUR;
            w_alu_op     = ALU_OP_ADD;
            w_illegal    = 1'b0;
            w_retire     = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3_i),
        .i_funct7b5    (funct7b5_i),
        .i_op_b5       (op_i[5]),
        .o_alu_control (w_alu_control)
    );

    assign pc_write_o      = w_pc_update | (w_branch & (zero_i ^ funct3_i[0]));
    assign adr_src_o       = w_adr_src;
    assign mem_write_o     = w_mem_write;
    assign ir_write_o      = w_ir_write;
    assign reg_write_o     = w_reg_write;
    assign result_src_o    = w_result_src;
    assign alu_src_a_o     = w_alu_src_a;
    assign alu_src_b_o     = w_alu_src_b;
    assign imm_src_o       = imm_src_for(op_i);
    assign alu_control_o   = w_alu_control;
    assign illegal_instr_o = w_illegal;
    assign instr_retire_o  = w_retire;
    assign state_o         = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued when an instruction is driven and compared at negedge.
module tb_multicycle_controller;
  import definitions_pkg::*;

  localparam int W = 22;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic        illegal_instr, instr_retire;
  ctrl_state_e dut_state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  multicycle_controller dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .op_i            (op),
    .funct3_i        (funct3),
    .funct7b5_i      (funct7b5),
    .zero_i          (zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready_i     (mem_ready),
`endif
    .pc_write_o      (pc_write),
    .adr_src_o       (adr_src),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .reg_write_o     (reg_write),
    .result_src_o    (result_src),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .imm_src_o       (imm_src),
    .alu_control_o   (alu_control),
    .illegal_instr_o (illegal_instr),
    .instr_retire_o  (instr_retire),
    .state_o         (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: state, pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill, ret
  function automatic logic [W-1:0] mk(input ctrl_state_e st, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic ill, input logic ret);
    return {st, pcw, adr, mw, irw, rw, res, a, b, imm, alu, ill, ret};
  endfunction

  logic [W-1:0] obs_vec;
  assign obs_vec = {dut_state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                    alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr, instr_retire};

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs_vec, e);
    end
  end

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [W-1:0] reset_vec(input ctrl_state_e st, input logic [1:0] imm);
    return mk(st, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction

  // driver: applies one instruction and queues its per-cycle expectations
  task automatic do_instr(input logic [31:0] instr, input logic z, input string name);
    logic [6:0] o;
    logic [2:0] f3;
    logic [1:0] im;
    logic       legal;
    int         n;
    o  = instr[6:0];
    f3 = instr[14:12];
    im = exp_imm(o);
    op = o; funct3 = f3; funct7b5 = instr[30]; zero = z;
    case (o)
      7'b0000011, 7'b0100011, 7'b1101111: legal = 1'b1;
      7'b0110011, 7'b0010011: legal = !(f3 == 3'b001 || f3 == 3'b101 || f3 == 3'b011);
      7'b1100011: legal = (f3 == 3'b000 || f3 == 3'b001);
      default: legal = 1'b0;
    endcase
    push({name, "_fetch"}, mk(FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0));
    push({name, "_decode"}, mk(DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000,
                               !legal, !legal));
    n = 2;
    if (legal) begin
      case (o)
        7'b0000011: begin
          push({name, "_memadr"}, mk(MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
          push({name, "_memread"}, mk(MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
          push({name, "_memwb"}, mk(MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 0, 1));
          n = 5;
        end
        7'b0100011: begin
          push({name, "_memadr"}, mk(MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
          push({name, "_memwrite"}, mk(MEMWRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
          n = 4;
        end
        7'b0110011: begin
          push({name, "_execr"}, mk(EXECUTER, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im,
                                    exp_alu(1'b1, f3, instr[30]), 0, 0));
          push({name, "_aluwb"}, mk(ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
          n = 4;
        end
        7'b0010011: begin
          push({name, "_execi"}, mk(EXECUTEI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im,
                                    exp_alu(1'b0, f3, instr[30]), 0, 0));
          push({name, "_aluwb"}, mk(ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
          n = 4;
        end
        7'b1100011: begin
          push({name, "_branch"}, mk(BRANCH, z ^ f3[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im,
                                     3'b001, 0, 1));
          n = 3;
        end
        default: begin
          push({name, "_jal"}, mk(JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, 0));
          push({name, "_aluwb"}, mk(ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
          n = 4;
        end
      endcase
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rand_tbl[12];

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    rand_tbl = '{32'h002081B3, 32'h402081B3, 32'h0000A183, 32'h0030A023, 32'h00208463,
                 32'h00209463, 32'h0080006F, 32'h00000000, 32'h002091B3, 32'h00500093,
                 32'h0020C1B3, 32'h0020C463};

    repeat (2) @(posedge clk);
    #1;
    push("reset_hold", reset_vec(FETCH, 2'b00));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset held three cycles in the middle of a lw
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    push("lwrst_fetch", mk(FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    push("lwrst_decode", mk(DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push("rst_c0", reset_vec(MEMADR, 2'b00));
    push("rst_c1", reset_vec(FETCH, 2'b00));
    push("rst_c2", reset_vec(FETCH, 2'b00));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    do_instr(32'h002081B3, 1'b0, "add");
    do_instr(32'h402081B3, 1'b0, "sub");
    do_instr(32'h0000A183, 1'b0, "lw");
    do_instr(32'h0030A023, 1'b0, "sw");
    do_instr(32'h00208463, 1'b1, "beq_taken");
    do_instr(32'h00208463, 1'b0, "beq_not");
    do_instr(32'h00209463, 1'b0, "bne_taken");
    do_instr(32'h00209463, 1'b1, "bne_not");
    do_instr(32'h0080006F, 1'b0, "jal");
    do_instr(32'h00000000, 1'b0, "illegal_zero");
    do_instr(32'h002091B3, 1'b0, "sll");
    do_instr(32'h00109093, 1'b0, "slli");
    do_instr(32'h0020C463, 1'b0, "blt");
    do_instr(32'h00500093, 1'b0, "addi");
    do_instr(32'h40000093, 1'b0, "addi_b30");
    do_instr(32'h0020A1B3, 1'b0, "slt");
    do_instr(32'h0020C1B3, 1'b0, "xor");
    do_instr(32'h0020E1B3, 1'b0, "or");
    do_instr(32'h0020F1B3, 1'b0, "and");

`ifdef MULTICYCLE_MEM_WAIT_EN
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push($sformatf("wait_fetch_c%0d", i),
           mk(FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    do_instr(32'h002081B3, 1'b0, "add_after_wait");
`endif

    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 11);
      do_instr(rand_tbl[k], 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    #1;
    check_eq("drain", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
